censor_mask_ctrl: RTL and testbench
===================================

CENSOR_MASK_CTRL -- requirements
Module: censor_mask_ctrl

Interface
REQ-001 SHALL have parameter COORD_W, default 11: width of pixel column/row coordinates.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port cfg_en, input, 1: censor enable for the next frame.
REQ-005 SHALL have ports cfg_x0, cfg_x1, input, COORD_W each: inclusive first/last masked column.
REQ-006 SHALL have ports cfg_y0, cfg_y1, input, COORD_W each: inclusive first/last masked row.
REQ-007 SHALL have port pix_valid, input, 1: one pixel accepted this cycle.
REQ-008 SHALL have port pix_sof, input, 1: start of frame; qualified by pix_valid.
REQ-009 SHALL have port pix_eol, input, 1: last pixel of line; qualified by pix_valid.
REQ-010 SHALL have port mask_bit, output, 1: registered mask decision for the delay line.
REQ-011 SHALL have port mask_valid, output, 1: mask_bit corresponds to an accepted pixel.
REQ-012 SHALL have port busy, output, 1: high while in ACTIVE.
REQ-013 SHALL have port err_sync, output, 1: one-cycle pulse on a framing error.

Function
REQ-014 SHALL implement FSM with states IDLE and ACTIVE.
REQ-015 IDLE: pixels without pix_sof ignored; mask_valid=0; counters hold 0.
REQ-016 IDLE->ACTIVE on pix_valid&pix_sof; that pixel is column 0, row 0 and is evaluated.
REQ-017 On every accepted SOF, SHALL latch cfg_en and cfg_x0/x1/y0/y1 into shadow registers; mid-frame input changes have no effect until the next SOF.
REQ-018 SHALL evaluate the SOF pixel against the values being latched in that same cycle.
REQ-019 Column counter x: +1 per accepted pixel; 0 after pixel with pix_eol; saturates at 2^COORD_W-1 without wrapping.
REQ-020 Row counter y: +1 after pixel with pix_eol; saturates at 2^COORD_W-1.
REQ-021 mask decision = shadow_en & x0<=x<=x1 & y0<=y<=y1, unsigned, inclusive, using the current pixel's coordinates.
REQ-022 x0>x1 or y0>y1 SHALL yield mask decision 0 for all pixels; no swap.
REQ-023 mask_bit and mask_valid SHALL be registered, latency 1 cycle from the accepted pixel.
REQ-024 mask_valid SHALL equal pix_valid of previous cycle when that pixel was evaluated (ACTIVE, or the IDLE->ACTIVE SOF pixel); else 0.
REQ-025 mask_bit SHALL be 0 whenever mask_valid is 0.
REQ-026 SOF in ACTIVE: resync; SOF pixel becomes (0,0); shadow registers reload; state stays ACTIVE.
REQ-027 err_sync SHALL pulse, 1 cycle after an accepted pixel, when that pixel is a SOF in ACTIVE with x!=0, or when x is saturated.
REQ-028 pix_sof&pix_eol on one pixel: SOF at (0,0) evaluated first, then x=0, y=1.
REQ-029 ACTIVE->IDLE only on reset; the block runs frame to frame via SOF.

Reset
REQ-030 rst_n low SHALL asynchronously force IDLE, x=y=0, shadow registers 0, mask_bit=0, mask_valid=0, busy=0, err_sync=0.
REQ-031 rst_n assertion mid-frame SHALL discard the frame; after release, output resumes only at the next SOF.
REQ-032 Release of rst_n SHALL take effect on the first clk edge after deassertion.

Verification
REQ-033 Region x0=2,x1=4,y0=1,y1=1, cfg_en=1, 8x3 frame, continuous valid -> mask_bit=1 only for row 1 columns 2..4 (3 pulses), each 1 cycle after its pixel.
REQ-034 Same frame with valid gaps (1-on/1-off) -> identical mask_bit sequence on mask_valid cycles; mask_valid=0 in gaps.
REQ-035 Change cfg_x0 from 2 to 0 mid-frame -> current frame unchanged; next frame masks columns 0..4.
REQ-036 Extra SOF at column 5 of row 1 -> err_sync pulse; counters restart at (0,0); no mask on pixels 0..1 of new row 0.
REQ-037 x0=5,x1=3 or cfg_en=0 -> mask_bit stays 0 for whole frame; mask_valid follows pix_valid.
REQ-038 rst_n low at row 1 column 3, released, pixels sent without SOF -> mask_valid stays 0 until next SOF.

Source files
------------

// File: rtl/censor_mask_ctrl.sv
// censor_mask_ctrl: per-pixel rectangular censor mask with SOF-latched region and framing checks.
// The pixel that carries SOF is scored against the region being captured on that same cycle.
module censor_mask_ctrl #(
   parameter int COORD_W = 11
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cfg_en,
   input  logic [COORD_W-1:0] cfg_x0,
   input  logic [COORD_W-1:0] cfg_x1,
   input  logic [COORD_W-1:0] cfg_y0,
   input  logic [COORD_W-1:0] cfg_y1,
   input  logic               pix_valid,
   input  logic               pix_sof,
   input  logic               pix_eol,
   output logic               mask_bit,
   output logic               mask_valid,
   output logic               busy,
   output logic               err_sync
);
   localparam logic IDLE = 1'b0;
   localparam logic ACTIVE = 1'b1;
   localparam logic [COORD_W-1:0] MAX = '1;

   logic               state_q, state_d;
   logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
   logic               en_q, en_d;
   logic [COORD_W-1:0] x0_q, x0_d, x1_q, x1_d, y0_q, y0_d, y1_q, y1_d;
   logic               mask_bit_q, mask_bit_d, mask_valid_q, mask_valid_d, err_q, err_d;
   logic               sof, eval, hit;
   logic [COORD_W-1:0] cx, cy;

   always_comb begin
      sof          = pix_valid & pix_sof;
      eval         = pix_valid & (state_q == ACTIVE | pix_sof);
      cx           = pix_sof ? '0 : x_q;
      cy           = pix_sof ? '0 : y_q;
      en_d         = sof ? cfg_en : en_q;
      x0_d         = sof ? cfg_x0 : x0_q;
      x1_d         = sof ? cfg_x1 : x1_q;
      y0_d         = sof ? cfg_y0 : y0_q;
      y1_d         = sof ? cfg_y1 : y1_q;
      // inverted bounds fall out naturally: no coordinate can satisfy both compares
      hit          = en_d & (x0_d <= cx) & (cx <= x1_d) & (y0_d <= cy) & (cy <= y1_d);
      state_d      = eval ? ACTIVE : state_q;
      x_d          = !eval ? x_q : pix_eol ? '0 : (cx == MAX) ? cx : cx + COORD_W'(1);
      y_d          = !eval ? y_q : (pix_eol && cy != MAX) ? cy + COORD_W'(1) : cy;
      mask_valid_d = eval;
      mask_bit_d   = eval & hit;
      err_d        = eval & ((sof & state_q == ACTIVE & x_q != '0) | cx == MAX);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         x_q          <= '0;
         y_q          <= '0;
         en_q         <= 1'b0;
         x0_q         <= '0;
         x1_q         <= '0;
         y0_q         <= '0;
         y1_q         <= '0;
         mask_bit_q   <= 1'b0;
         mask_valid_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         x_q          <= x_d;
         y_q          <= y_d;
         en_q         <= en_d;
         x0_q         <= x0_d;
         x1_q         <= x1_d;
         y0_q         <= y0_d;
         y1_q         <= y1_d;
         mask_bit_q   <= mask_bit_d;
         mask_valid_q <= mask_valid_d;
         err_q        <= err_d;
      end
   end

   assign mask_bit   = mask_bit_q;
   assign mask_valid = mask_valid_q;
   assign busy       = state_q == ACTIVE;
   assign err_sync   = err_q;
endmodule

// File: tb/tb_censor_mask_ctrl.sv
// tb_censor_mask_ctrl: directed frames checked every cycle against an integer frame model,
// with literal pulse counts pinning the model for the key scenarios.
module tb_censor_mask_ctrl;
   localparam int W = 11;
   localparam int MAXC = (1 << W) - 1;

   logic         clk = 1'b0, rst_n = 1'b0;
   logic         cfg_en = 1'b0;
   logic [W-1:0] cfg_x0 = '0, cfg_x1 = '0, cfg_y0 = '0, cfg_y1 = '0;
   logic         pix_valid = 1'b0, pix_sof = 1'b0, pix_eol = 1'b0;
   logic         mask_bit, mask_valid, busy, err_sync;

   int vectors = 0, miss = 0, nmask = 0, nerr = 0, nvalid = 0;
   bit chk = 1'b0;

   int m_act, mx, my, sen, sx0, sx1, sy0, sy1;
   bit ev, eb, ee, ebusy;

   censor_mask_ctrl #(.COORD_W(W)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en),
      .cfg_x0(cfg_x0), .cfg_x1(cfg_x1), .cfg_y0(cfg_y0), .cfg_y1(cfg_y1),
      .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_eol(pix_eol),
      .mask_bit(mask_bit), .mask_valid(mask_valid), .busy(busy), .err_sync(err_sync)
   );

   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n) begin : model
      int cx, cy, e, a, b, c, d;
      bit ok, hit;
      if (!rst_n) begin
         m_act <= 0; mx <= 0; my <= 0;
         sen <= 0; sx0 <= 0; sx1 <= 0; sy0 <= 0; sy1 <= 0;
         ev <= 0; eb <= 0; ee <= 0; ebusy <= 0;
      end else begin
         ok = pix_valid && (m_act != 0 || pix_sof);
         cx = pix_sof ? 0 : mx;
         cy = pix_sof ? 0 : my;
         e = pix_sof ? int'(cfg_en) : sen;
         a = pix_sof ? int'(cfg_x0) : sx0;
         b = pix_sof ? int'(cfg_x1) : sx1;
         c = pix_sof ? int'(cfg_y0) : sy0;
         d = pix_sof ? int'(cfg_y1) : sy1;
         hit = e != 0 && cx >= a && cx <= b && cy >= c && cy <= d;
         ev <= ok;
         eb <= ok && hit;
         ee <= ok && ((pix_sof && m_act != 0 && mx != 0) || cx == MAXC);
         ebusy <= m_act != 0 || ok;
         if (ok) begin
            m_act <= 1;
            sen <= e; sx0 <= a; sx1 <= b; sy0 <= c; sy1 <= d;
            mx <= pix_eol ? 0 : (cx == MAXC ? cx : cx + 1);
            my <= pix_eol ? (cy == MAXC ? cy : cy + 1) : cy;
         end
      end
   end

   always @(negedge clk) begin
      if (chk) begin
         vectors++;
         if ({mask_valid, mask_bit, err_sync, busy} !== {ev, eb, ee, ebusy}) begin
            miss++;
            $display("FAIL cycle t=%0t {valid,bit,err,busy} got=%b%b%b%b want=%b%b%b%b",
                     $time, mask_valid, mask_bit, err_sync, busy, ev, eb, ee, ebusy);
         end
         nmask += int'(mask_bit);
         nerr += int'(err_sync);
         nvalid += int'(mask_valid);
      end
   end

   task automatic lit(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miss++;
         $display("FAIL %s got=%0d want=%0d", name, act, exp);
      end
   endtask

   task automatic px(input bit v, input bit s, input bit e);
      pix_valid = v; pix_sof = s; pix_eol = e;
      @(posedge clk); #1;
      pix_valid = 0; pix_sof = 0; pix_eol = 0;
   endtask

   task automatic frame(input int w, input int h, input bit gap, input bit chg);
      for (int y = 0; y < h; y++)
         for (int x = 0; x < w; x++) begin
            if (chg && y == 0 && x == 4) cfg_x0 = 0;
            px(1, x == 0 && y == 0, x == w - 1);
            if (gap) px(0, 0, 0);
         end
      px(0, 0, 0);
      px(0, 0, 0);
   endtask

   task automatic region(input bit en, input int a, input int b, input int c, input int d);
      cfg_en = en; cfg_x0 = W'(a); cfg_x1 = W'(b); cfg_y0 = W'(c); cfg_y1 = W'(d);
      nmask = 0; nerr = 0; nvalid = 0;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      lit("reset_mask_valid", int'(mask_valid), 0);
      lit("reset_busy", int'(busy), 0);
      lit("reset_err", int'(err_sync), 0);
      rst_n = 1;
      chk = 1;
      px(1, 0, 0);
      px(1, 0, 1);

      region(1, 2, 4, 1, 1);
      frame(8, 3, 0, 0);
      lit("basic_mask_pulses", nmask, 3);
      lit("basic_valid_count", nvalid, 24);

      region(1, 2, 4, 1, 1);
      frame(8, 3, 1, 0);
      lit("gap_mask_pulses", nmask, 3);
      lit("gap_valid_count", nvalid, 24);

      region(1, 2, 4, 1, 1);
      frame(8, 3, 0, 1);
      lit("midframe_cfg_ignored", nmask, 3);
      nmask = 0;
      frame(8, 3, 0, 0);
      lit("next_frame_cfg_used", nmask, 5);

      region(1, 2, 4, 1, 1);
      for (int x = 0; x < 8; x++) px(1, x == 0, x == 7);
      for (int x = 0; x < 5; x++) px(1, 0, 0);
      for (int x = 0; x < 8; x++) px(1, x == 0, x == 7);
      for (int x = 0; x < 8; x++) px(1, 0, x == 7);
      px(0, 0, 0);
      px(0, 0, 0);
      lit("resync_err_pulses", nerr, 1);
      lit("resync_mask_pulses", nmask, 6);

      region(1, 5, 3, 0, 2);
      frame(8, 3, 0, 0);
      lit("inverted_x_no_mask", nmask, 0);
      lit("inverted_x_valid", nvalid, 24);
      region(0, 2, 4, 1, 1);
      frame(8, 3, 1, 0);
      lit("disabled_no_mask", nmask, 0);

      region(1, 0, 7, 0, 2);
      for (int x = 0; x < 8; x++) px(1, x == 0, x == 7);
      for (int x = 0; x < 3; x++) px(1, 0, 0);
      pix_valid = 1;
      #2 rst_n = 0;
      #1;
      lit("async_reset_valid", int'(mask_valid), 0);
      lit("async_reset_busy", int'(busy), 0);
      pix_valid = 0;
      @(posedge clk); #1;
      rst_n = 1;
      nvalid = 0;
      for (int x = 0; x < 10; x++) px(1, 0, x == 4);
      px(0, 0, 0);
      lit("no_output_before_sof", nvalid, 0);
      frame(4, 2, 0, 0);
      lit("resume_after_sof", nvalid, 8);

      region(1, 0, MAXC, 0, 0);
      px(1, 1, 0);
      for (int x = 0; x < 2049; x++) px(1, 0, 0);
      px(1, 0, 1);
      px(1, 0, 1);
      px(0, 0, 0);
      px(0, 0, 0);
      lit("saturation_err_pulses", nerr, 4);
      lit("saturation_mask_pulses", nmask, 2051);

      region(1, 0, 0, 1, 1);
      px(1, 1, 1);
      px(1, 0, 1);
      px(1, 0, 0);
      px(0, 0, 0);
      px(0, 0, 0);
      lit("sof_eol_row1_masked", nmask, 1);

      chk = 0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout");
      $fatal(1);
   end
endmodule
